// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage load/store engine driving a single-beat strobe/ack data bus
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall[5:0]                pipeline stall vector, stall[4] holds MEM/WB
//   mem_wd/wreg/wdata/aluop   EX/MEM register outputs
//   mem_mem_addr, mem_reg2    effective address and store data
//   wb_wd/wreg/wdata          results to MEM/WB
//   stallreq                  stall request while a bus access is outstanding
//   bus_*                     big-endian data bus (addr[1:0]=00 is bits 31:24)
//   misalign_o                misaligned-access flag, present only with ALIGN_EXC_EN
// Build option ALIGN_EXC_EN: misaligned accesses are flagged instead of being
// forced onto the aligned half/word.
module mem_bus_if #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [31:0]       mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [31:0]       mem_mem_addr,
    input  logic [31:0]       mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [31:0]       wb_wdata,
    output logic              stallreq,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_data_o,
    output logic [3:0]        bus_sel_o,
    output logic              bus_we_o,
    output logic              bus_stb_o,
`ifdef ALIGN_EXC_EN
    output logic              misalign_o,
`endif
    input  logic [31:0]       bus_data_i,
    input  logic              bus_ack_i
);
    localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
    localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
    localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
    localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
    localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
    localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
    localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
    localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
    localparam logic       NO_STOP = 1'b0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] rd_buf;
    logic        is_byte, is_half, is_word, is_load, is_store, is_mem;
    logic        bad, start, req;
    logic [3:0]  lanes;
    logic [31:0] st_data, ld_data;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic        unused_ok;

    assign unused_ok = ^{stall[5], stall[3:0]};

    always_comb begin
        is_byte  = mem_aluop == EXE_LB_OP || mem_aluop == EXE_LBU_OP || mem_aluop == EXE_SB_OP;
        is_half  = mem_aluop == EXE_LH_OP || mem_aluop == EXE_LHU_OP || mem_aluop == EXE_SH_OP;
        is_word  = mem_aluop == EXE_LW_OP || mem_aluop == EXE_SW_OP;
        is_store = mem_aluop == EXE_SB_OP || mem_aluop == EXE_SH_OP || mem_aluop == EXE_SW_OP;
        is_mem   = is_byte || is_half || is_word;
        is_load  = is_mem && !is_store;
`ifdef ALIGN_EXC_EN
        bad = (is_half && mem_mem_addr[0]) || (is_word && mem_mem_addr[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        start = is_mem && !bad;
        // strobe is combinational in IDLE so a same-cycle ack completes immediately
        req = !rst && ((state == IDLE && start) || state == BUSY);
        lanes = is_byte ? 4'b1000 >> mem_mem_addr[1:0] :
                is_half ? (mem_mem_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        st_data = mem_aluop == EXE_SB_OP ? {4{mem_reg2[7:0]}} :
                  mem_aluop == EXE_SH_OP ? {2{mem_reg2[15:0]}} :
                  mem_aluop == EXE_SW_OP ? mem_reg2 : 32'h0;
        ld_b = rd_buf[{~mem_mem_addr[1:0], 3'b000} +: 8];
        ld_h = rd_buf[{~mem_mem_addr[1], 4'b0000} +: 16];
        ld_data = mem_aluop == EXE_LB_OP  ? {{24{ld_b[7]}}, ld_b} :
                  mem_aluop == EXE_LBU_OP ? {24'h0, ld_b} :
                  mem_aluop == EXE_LH_OP  ? {{16{ld_h[15]}}, ld_h} :
                  mem_aluop == EXE_LHU_OP ? {16'h0, ld_h} : rd_buf;
        bus_stb_o  = req;
        bus_we_o   = req && is_store;
        bus_sel_o  = req ? lanes : 4'h0;
        bus_addr_o = req ? {mem_mem_addr[ADDR_W-1:2], 2'b00} : '0;
        bus_data_o = req ? st_data : 32'h0;
        stallreq   = req;
        wb_wd      = rst ? NOP_REG_ADDR : mem_wd;
        wb_wreg    = !rst && mem_wreg && !bad;
        wb_wdata   = rst ? 32'h0 : (state == DONE && is_load) ? ld_data : mem_wdata;
`ifdef ALIGN_EXC_EN
        misalign_o = !rst && bad;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rd_buf <= 32'h0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    if (bus_ack_i) rd_buf <= bus_data_i;
                    state <= bus_ack_i ? DONE : BUSY;
                end
                BUSY: if (bus_ack_i) begin
                    rd_buf <= bus_data_i;
                    state  <= DONE;
                end
                DONE: if (stall[4] == NO_STOP) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed self-checking bench for mem_bus_if
module tb_mem_bus_if;
    localparam logic [7:0] ADD = 8'b00100000;
    localparam logic [7:0] LB  = 8'b11100000;
    localparam logic [7:0] LBU = 8'b11100100;
    localparam logic [7:0] LW  = 8'b11100011;
    localparam logic [7:0] SH  = 8'b11101001;

    logic        clk = 0, rst = 1;
    logic [5:0]  stall = 0;
    logic [4:0]  mem_wd = 0;
    logic        mem_wreg = 0;
    logic [31:0] mem_wdata = 0, mem_mem_addr = 0, mem_reg2 = 0, bus_data_i = 0;
    logic [7:0]  mem_aluop = 0;
    logic        bus_ack_i = 0;
    logic [4:0]  wb_wd;
    logic        wb_wreg, stallreq, bus_we_o, bus_stb_o;
    logic [31:0] wb_wdata, bus_addr_o, bus_data_o;
    logic [3:0]  bus_sel_o;
`ifdef ALIGN_EXC_EN
    logic        misalign_o;
`endif
    int checks = 0, errors = 0, stb_cnt = 0, cnt0 = 0, hi = 0;

    mem_bus_if dut (
        .clk(clk), .rst(rst), .stall(stall), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_sel_o(bus_sel_o), .bus_we_o(bus_we_o), .bus_stb_o(bus_stb_o),
`ifdef ALIGN_EXC_EN
        .misalign_o(misalign_o),
`endif
        .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus_stb_o) stb_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_aluop = LW; mem_wd = 7; mem_wreg = 1; mem_wdata = 32'h99;
        #2;
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_sel", bus_sel_o, 0);
        chk("rst_wb_wd", wb_wd, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_wb_wdata", wb_wdata, 0);
        step();
        mem_aluop = ADD; mem_wdata = 32'h12345678; mem_wd = 5;
        rst = 0;
        #1;
        cnt0 = stb_cnt;
        for (int i = 0; i < 3; i++) begin
            chk("add_wdata", wb_wdata, 32'h12345678);
            chk("add_wd", wb_wd, 5);
            chk("add_stallreq", stallreq, 0);
            step();
        end
        chk("add_no_stb", stb_cnt - cnt0, 0);
        // LB with ack three cycles late
        mem_aluop = LB; mem_mem_addr = 32'h101; bus_data_i = 32'h11F02233; mem_wd = 9;
        #1;
        chk("lb_sel", bus_sel_o, 4'b0100);
        chk("lb_addr", bus_addr_o, 32'h100);
        chk("lb_we", bus_we_o, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bus_ack_i = 1; #1; end
            chk("lb_sel_hold", bus_sel_o, 4'b0100);
            if (stallreq) hi++;
            step();
        end
        bus_ack_i = 0;
        #1;
        chk("lb_stall_cycles", hi, 4);
        chk("lb_done_stallreq", stallreq, 0);
        chk("lb_done_stb", bus_stb_o, 0);
        chk("lb_wdata", wb_wdata, 32'hFFFFFFF0);
        chk("lb_wd", wb_wd, 9);
        chk("lb_wreg", wb_wreg, 1);
        mem_aluop = LBU;
        step();
        bus_ack_i = 1;
        #1;
        chk("lbu_stb", bus_stb_o, 1);
        step();
        bus_ack_i = 0;
        #1;
        chk("lbu_wdata", wb_wdata, 32'h000000F0);
        chk("lbu_stallreq", stallreq, 0);
        // SH with same-cycle ack
        mem_aluop = SH; mem_mem_addr = 32'h202; mem_reg2 = 32'hAAAABEEF; mem_wdata = 32'h77;
        step();
        bus_ack_i = 1;
        #1;
        chk("sh_data", bus_data_o, 32'hBEEFBEEF);
        chk("sh_sel", bus_sel_o, 4'b0011);
        chk("sh_we", bus_we_o, 1);
        chk("sh_addr", bus_addr_o, 32'h200);
        step();
        bus_ack_i = 0;
        #1;
        chk("sh_done_stallreq", stallreq, 0);
        chk("sh_done_stb", bus_stb_o, 0);
        chk("sh_wdata", wb_wdata, 32'h77);
        // LW then MEM/WB hold for two cycles
        mem_aluop = LW; mem_mem_addr = 32'h10; bus_data_i = 32'hCAFEF00D;
        step();
        cnt0 = stb_cnt;
        bus_ack_i = 1;
        #1;
        chk("lw_stb", bus_stb_o, 1);
        step();
        bus_ack_i = 0; stall = 6'b010000; bus_data_i = 32'h0;
        #1;
        chk("lw_wdata", wb_wdata, 32'hCAFEF00D);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lw_hold_wdata", wb_wdata, 32'hCAFEF00D);
            chk("lw_hold_stallreq", stallreq, 0);
            chk("lw_hold_stb", bus_stb_o, 0);
        end
        stall = 0; mem_aluop = ADD;
        step();
        chk("lw_single_txn", stb_cnt - cnt0, 1);
        // reset pulse in BUSY
        mem_aluop = LW; mem_mem_addr = 32'h20;
        step();
        step();
        chk("busy_stb", bus_stb_o, 1);
        rst = 1;
        #1;
        chk("rst_busy_stb", bus_stb_o, 0);
        chk("rst_busy_stallreq", stallreq, 0);
        bus_ack_i = 1; bus_data_i = 32'hDEADDEAD;
        step();
        rst = 0; bus_ack_i = 0; bus_data_i = 32'h01020304;
        #1;
        chk("restart_stb", bus_stb_o, 1);
        chk("restart_addr", bus_addr_o, 32'h20);
        chk("restart_stallreq", stallreq, 1);
        step();
        chk("restart_busy", stallreq, 1);
        bus_ack_i = 1;
        step();
        bus_ack_i = 0;
        #1;
        chk("restart_wdata", wb_wdata, 32'h01020304);
        // misaligned LW
        mem_mem_addr = 32'h6; bus_data_i = 32'h55667788;
        step();
`ifdef ALIGN_EXC_EN
        chk("mis_flag", misalign_o, 1);
        chk("mis_stb", bus_stb_o, 0);
        chk("mis_wreg", wb_wreg, 0);
        chk("mis_stallreq", stallreq, 0);
`else
        chk("mis_addr", bus_addr_o, 32'h4);
        chk("mis_sel", bus_sel_o, 4'b1111);
        chk("mis_stb", bus_stb_o, 1);
        bus_ack_i = 1;
        step();
        bus_ack_i = 0;
        #1;
        chk("mis_wdata", wb_wdata, 32'h55667788);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
